// File: rtl/multi_digit_display_pkg.sv
// Segment and anode constants shared by the display controller and its decoder.
// Segments are {g,f,e,d,c,b,a}, active-low.
package multi_digit_display_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Anodes are active-low on the board.
  localparam logic ANODE_OFF = 1'b1;
  localparam logic ANODE_ON  = 1'b0;

endpackage

// File: rtl/multi_digit_display_hex_to_seven_seg.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex_to_seven_seg
  import multi_digit_display_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (hex_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/multi_digit_display.sv
// Time-multiplexed hex display with frame-synchronous capture, per-digit enable and hold.
// Optional leading-zero blanking is enabled by defining MULTI_DIGIT_DISPLAY_LZB_EN.
module multi_digit_display
  import multi_digit_display_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic [4*NUM_DIGITS-1:0] Number,
  input  logic [NUM_DIGITS-1:0]   DigitEn,
  input  logic                    Hold,
  output logic [6:0]              out7,
  output logic [NUM_DIGITS-1:0]   en_out,
  output logic                    FrameStart
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] frame_q, frame_d;
  logic                    pending_q;
  logic [6:0]              out7_q, out7_d;
  logic [NUM_DIGITS-1:0]   en_q, en_d;
  logic                    fs_q, fs_d;

  logic                    slot_end;
  logic                    frame_wrap;
  logic [4*NUM_DIGITS-1:0] disp_frame;
  logic [3:0]              nibble;
  logic [6:0]              seg;
  logic                    lit;

  always_comb begin
    slot_end   = (cnt_q == CNT_LAST);
    frame_wrap = slot_end && (idx_q == IDX_LAST);
    cnt_d      = slot_end ? '0 : cnt_q + 1'b1;
    idx_d      = idx_q;
    if (slot_end) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    frame_d = frame_q;
    if (pending_q || (frame_wrap && !Hold)) frame_d = Number;
  end

  // The post-reset capture is shown in the very first slot, so read it straight through.
  assign disp_frame = pending_q ? Number : frame_q;
  assign nibble     = disp_frame[{idx_q, 2'b00} +: 4];

  hex_to_seven_seg u_dec (
    .hex_i (nibble),
    .seg_o (seg)
  );

`ifdef MULTI_DIGIT_DISPLAY_LZB_EN
  logic [NUM_DIGITS-1:0] lzb_vis;
  logic                  nz_seen;

  // Walk from the most significant digit down; digit 0 is always visible.
  always_comb begin
    lzb_vis = '0;
    nz_seen = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nz_seen    = nz_seen | (disp_frame[4*i +: 4] != 4'h0);
      lzb_vis[i] = nz_seen | (i == 0);
    end
  end

  assign lit = DigitEn[idx_q] & lzb_vis[idx_q];
`else
  assign lit = DigitEn[idx_q];
`endif

  always_comb begin
    en_d = {NUM_DIGITS{ANODE_OFF}};
    if (lit) en_d[idx_q] = ANODE_ON;
    out7_d = lit ? seg : SEG_BLANK;
    fs_d   = (idx_q == '0) && (cnt_q == '0);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      frame_q   <= '0;
      pending_q <= 1'b1;
      out7_q    <= SEG_BLANK;
      en_q      <= {NUM_DIGITS{ANODE_OFF}};
      fs_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      frame_q   <= frame_d;
      pending_q <= 1'b0;
      out7_q    <= out7_d;
      en_q      <= en_d;
      fs_q      <= fs_d;
    end
  end

  assign out7       = out7_q;
  assign en_out     = en_q;
  assign FrameStart = fs_q;

endmodule

// File: tb/tb_multi_digit_display.sv
// Directed bench for multi_digit_display with NUM_DIGITS=8, REFRESH_DIV=4.
// Cycle k is the falling edge after the k-th rising edge since reset release.
module tb_multi_digit_display;

  logic        Clk;
  logic        Rst;
  logic [31:0] Number;
  logic [7:0]  DigitEn;
  logic        Hold;
  logic [6:0]  out7;
  logic [7:0]  en_out;
  logic        FrameStart;

  int n_tests = 0;
  int n_fail  = 0;
  int k       = 0;

  multi_digit_display #(
    .NUM_DIGITS  (8),
    .REFRESH_DIV (4)
  ) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .Number     (Number),
    .DigitEn    (DigitEn),
    .Hold       (Hold),
    .out7       (out7),
    .en_out     (en_out),
    .FrameStart (FrameStart)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(negedge Clk);
    k++;
  endtask

  task automatic tick_to(input int target);
    while (k < target) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, k);
    end
  endtask

  initial begin
    logic [7:0] exp_en;
    int d;

    Rst = 1'b1; Number = 32'h000012AB; DigitEn = 8'hFF; Hold = 1'b0;
    repeat (3) @(negedge Clk);
    check("rst_out7", out7, 7'h7F);
    check("rst_en", en_out, 8'hFF);
    check("rst_fs", FrameStart, 1'b0);

    Rst = 1'b0; k = 0;
    tick();
    check("first_en", en_out, 8'hFE);
    check("first_out7", out7, 7'b0000011);
    check("first_fs", FrameStart, 1'b1);
    tick();
    check("fs_single", FrameStart, 1'b0);
    tick_to(5);
    check("slot1_en", en_out, 8'hFD);
    check("slot1_out7", out7, 7'b0001000);

    // scan walk through a full frame and back to digit 0
    while (k < 33) begin
      tick();
      d = ((k - 1) / 4) % 8;
      exp_en = ~(8'h01 << d);
      check("scan_en", en_out, exp_en);
      check("scan_fs", FrameStart, ((k - 1) % 32) == 0);
      if (k == 9)  check("scan_d2", out7, 7'b0100100);
      if (k == 13) check("scan_d3", out7, 7'b1111001);
    end

    // frame-synchronous capture
    tick_to(45);
    Number = 32'hFFFFFFFF;
    tick_to(49);
    check("fsync_d4_out7", out7, 7'b1000000);
    check("fsync_d4_en", en_out, 8'hEF);
    tick_to(61);
    check("fsync_d7_out7", out7, 7'b1000000);
    check("fsync_d7_en", en_out, 8'h7F);
    tick_to(65);
    check("fsync_new_out7", out7, 7'b0001110);
    check("fsync_new_en", en_out, 8'hFE);
    check("fsync_new_fs", FrameStart, 1'b1);

    // hold across a boundary
    tick_to(70);
    Hold = 1'b1; Number = 32'h11111111;
    tick_to(97);
    check("hold_keep", out7, 7'b0001110);
    check("hold_fs", FrameStart, 1'b1);
    tick_to(100);
    Hold = 1'b0;
    tick_to(101);
    check("hold_mid", out7, 7'b0001110);
    tick_to(129);
    check("hold_release", out7, 7'b1111001);
    check("hold_release_en", en_out, 8'hFE);

    // per-digit enable
    tick_to(130);
    DigitEn = 8'h0F;
    tick_to(141);
    check("den_d3_en", en_out, 8'hF7);
    check("den_d3_out7", out7, 7'b1111001);
    tick_to(145);
    check("den_d4_en", en_out, 8'hFF);
    check("den_d4_out7", out7, 7'h7F);
    tick_to(149);
    check("den_d5_en", en_out, 8'hFF);
    check("den_d5_out7", out7, 7'h7F);
    DigitEn = 8'hFF;
    tick_to(150);
    check("den_live_en", en_out, 8'hDF);
    check("den_live_out7", out7, 7'b1111001);

    // asynchronous reset mid-slot
    #2 Rst = 1'b1;
    #1;
    check("arst_en", en_out, 8'hFF);
    check("arst_out7", out7, 7'h7F);
    check("arst_fs", FrameStart, 1'b0);
    Number = 32'h76543210; Hold = 1'b1;
    repeat (2) @(negedge Clk);
    Rst = 1'b0; k = 0;
    tick();
    check("restart_en", en_out, 8'hFE);
    check("restart_out7", out7, 7'b1000000);
    check("restart_fs", FrameStart, 1'b1);
    tick_to(5);
    check("pend_capture_d1", out7, 7'b1111001);
    tick_to(9);
    check("pend_capture_d2", out7, 7'b0100100);

    // leading zeros
    Hold = 1'b0; Number = 32'h000000A5;
    tick_to(33);
    check("lz_d0_en", en_out, 8'hFE);
    check("lz_d0_out7", out7, 7'b0010010);
    tick_to(37);
    check("lz_d1_en", en_out, 8'hFD);
    check("lz_d1_out7", out7, 7'b0001000);
    tick_to(40);
    Number = 32'h00000000;
    tick_to(41);
`ifdef MULTI_DIGIT_DISPLAY_LZB_EN
    check("lz_d2_en", en_out, 8'hFF);
    check("lz_d2_out7", out7, 7'h7F);
`else
    check("lz_d2_en", en_out, 8'hFB);
    check("lz_d2_out7", out7, 7'b1000000);
`endif
    tick_to(61);
`ifdef MULTI_DIGIT_DISPLAY_LZB_EN
    check("lz_d7_en", en_out, 8'hFF);
    check("lz_d7_out7", out7, 7'h7F);
`else
    check("lz_d7_en", en_out, 8'h7F);
    check("lz_d7_out7", out7, 7'b1000000);
`endif
    tick_to(65);
    check("zero_d0_en", en_out, 8'hFE);
    check("zero_d0_out7", out7, 7'b1000000);
    tick_to(69);
`ifdef MULTI_DIGIT_DISPLAY_LZB_EN
    check("zero_d1_en", en_out, 8'hFF);
    check("zero_d1_out7", out7, 7'h7F);
`else
    check("zero_d1_en", en_out, 8'hFD);
    check("zero_d1_out7", out7, 7'b1000000);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
